tlb_assoc: RTL and testbench
============================

// Module: tlb_assoc
// PURPOSE
//  Parametrised, set-associative Sv32 TLB for one memory port (I or D), between the
//  pipeline memory stage and the page-table walker. Translates a VA to a PPN. Checks
//  R/W/X/U/A/D permissions, raises the fault to the hazard unit, and requests a walk
//  on a miss. Supports sfence.vma flush, by ASID or all, and bare/M-mode passthrough.
// PARAMETERS
//  SETS      8   number of sets, power of 2 and >=2; index = vaddr[12 +: log2(SETS)]
//  WAYS      2   ways per set, power of 2 and >=1; round-robin replacement per set
//  ASID_W    9   ASID width (satp.asid)
//  PPN_W     22  physical page number width
// PORTS
//  CLK            in   1      clock
//  nRST           in   1      asynchronous active-low reset
//  satp_mode      in   1      0 = bare, 1 = Sv32
//  satp_asid      in   ASID_W current ASID
//  priv_level     in   2      current privilege (U=0, S=1, M=3)
//  sum            in   1      mstatus.SUM: S-mode may access U pages (loads/stores only)
//  req_valid      in   1      translation request
//  req_ready      out  1      TLB accepts request this cycle
//  req_vaddr      in   32     virtual address
//  req_acc        in   2      access type: 0 = load, 1 = store, 2 = fetch
//  rsp_valid      out  1      one-cycle pulse: response valid
//  rsp_ppn        out  PPN_W  translated PPN
//  rsp_fault      out  1      page fault (tlb_if.fault)
//  walk_req       out  1      walk request; held high until walk_done
//  walk_vpn       out  20     VPN to walk
//  walk_done      in   1      one-cycle pulse: walk finished
//  walk_pte       in   32     leaf PTE {ppn[31:10], rsw, D, A, G, U, X, W, R, V}
//  walk_mega      in   1      leaf is a 4 MiB megapage
//  walk_err       in   1      walk failed (invalid or misaligned PTE)
//  flush_req      in   1      sfence.vma, sampled when req_ready=1
//  flush_all      in   1      1 = flush every entry; 0 = flush non-global entries of flush_asid
//  flush_asid     in   ASID_W ASID to flush
//  flush_done     out  1      one-cycle pulse when the flush completes
// BEHAVIOUR
//  Reset: all entries V=0, RR pointers 0, state IDLE, req_ready=1.
//   All other outputs are 0 during and after reset.
//  FSM IDLE/RESP/WALK/FLUSH; req_ready=1 only in IDLE. flush_req has priority
//   over req_valid in the same cycle.
//  Passthrough: if satp_mode=0 or priv_level=M, then rsp_valid in the next cycle,
//   rsp_ppn={2'b0,vaddr[31:12]}, rsp_fault=0. TLB is not accessed.
//  Hit condition: V && (G || asid==satp_asid) && (mega ? vpn1 match : vpn match).
//   Go IDLE->RESP; the response is registered with latency 1 cycle.
//   For a megapage: rsp_ppn={ppn[21:10], vaddr[21:12]}.
//  Miss: IDLE->WALK, walk_req=1, walk_vpn=vaddr[31:12]. On walk_done:
//   - If walk_err=0, write the victim way at the RR pointer, then advance the pointer
//     (wraps at WAYS-1). Prefer an invalid way first (lowest index), without advancing.
//   - Then RESP the next cycle, applying the permission check to the new entry.
//   - If walk_err=1, do not fill; RESP with fault=1.
//  Fault rules (any true -> rsp_fault=1, rsp_ppn=0):
//   - load with R=0 (MXR not supported); store with W=0; fetch with X=0
//   - U=1 and S-mode with fetch, or with sum=0
//   - U=0 and U-mode; A=0; store with D=0 (no hardware A/D update)
//   - megapage with ppn[9:0]!=0
//  Faulting translations remain cached; the check repeats on every hit.
//  FLUSH: one set per cycle, index 0..SETS-1, so SETS cycles total.
//   flush_done pulses on the last cycle, then IDLE. Entries with G=1 survive a
//   non-all flush. A flush during WALK is not possible (req_ready=0).
//  Same-cycle fill and lookup cannot occur (single outstanding request).
//  Asynchronous reset mid-WALK or mid-FLUSH: return immediately to the reset state;
//   walk_req drops.
// TESTING
//  Sv32, S-mode, load 0x4000_1234 with a cold TLB -> walk_req=1, walk_vpn=0x40001.
//   Walk PTE ppn=0x12345 with V,R,A set -> rsp_ppn=0x12345, fault=0.
//   Repeat the load -> hit, 1-cycle latency, no walk_req.
//  Store to a page with W=1, D=0 -> rsp_fault=1. Load to the same page -> fault=0.
//  Fill WAYS+1 distinct VPNs mapping to set 0 -> the first fill is evicted by RR,
//   and re-accessing it walks again.
//  Entries for ASID 3 and ASID 5, plus a G entry; flush_all=0, asid=3 ->
//   flush_done after SETS cycles; ASID 5 and G entries hit, ASID 3 misses.
//  satp_mode=0, vaddr 0xFFFF_F000 -> rsp_ppn=0x0FFFFF, no walk.
//   Assert nRST during WALK -> walk_req=0, req_ready=1, TLB empty.

Source files
------------

// File: rtl/tlb_assoc.sv
// tlb_assoc: set-associative Sv32 TLB for one memory port (I or D).
//
// It translates a virtual address to a PPN and checks the R/W/X/U/A/D
// permissions. On a miss it asks the page-table walker for the leaf PTE and
// fills the entry. It supports sfence.vma, either for one ASID or for all
// entries. When satp is bare or the hart is in M-mode, the address passes
// through untranslated.
//
// Ports
//   CLK, nRST                     clock, asynchronous active-low reset
//   satp_mode, satp_asid          translation enable and current ASID
//   priv_level, sum               privilege (U=0, S=1, M=3) and mstatus.SUM
//   req_valid/ready/vaddr/acc     translation request (acc: 0 ld, 1 st, 2 fetch)
//   rsp_valid/ppn/fault           one-cycle response pulse
//   walk_req/vpn                  walk request, held until walk_done
//   walk_done/pte/mega/err        walk result (one-cycle pulse)
//   flush_req/all/asid            sfence.vma, accepted while req_ready=1
//   flush_done                    pulses on the last flush cycle
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for a request or a flush; lookup happens here
// S_RESP  | registered response presented (rsp_valid=1)
// S_WALK  | miss outstanding, walk_req held until walk_done
// S_FLUSH | invalidating one set per cycle, index 0..SETS-1
module tlb_assoc #(
  parameter int SETS   = 8,
  parameter int WAYS   = 2,
  parameter int ASID_W = 9,
  parameter int PPN_W  = 22
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              satp_mode,
  input  logic [ASID_W-1:0] satp_asid,
  input  logic [1:0]        priv_level,
  input  logic              sum,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_vaddr,
  input  logic [1:0]        req_acc,
  output logic              rsp_valid,
  output logic [PPN_W-1:0]  rsp_ppn,
  output logic              rsp_fault,
  output logic              walk_req,
  output logic [19:0]       walk_vpn,
  input  logic              walk_done,
  input  logic [31:0]       walk_pte,
  input  logic              walk_mega,
  input  logic              walk_err,
  input  logic              flush_req,
  input  logic              flush_all,
  input  logic [ASID_W-1:0] flush_asid,
  output logic              flush_done
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] ACC_STORE = 2'd1;
  localparam logic [1:0] ACC_FETCH = 2'd2;
  localparam logic [1:0] PRIV_U    = 2'd0;
  localparam logic [1:0] PRIV_S    = 2'd1;
  localparam logic [1:0] PRIV_M    = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_WALK, S_FLUSH} state_t;
  state_t state_q, state_d;

  // Entry storage. Only the valid bits need reset; flags hold PTE[7:1] = {D,A,G,U,X,W,R}.
  logic [WAYS-1:0]   v_q    [SETS];
  logic [WAY_W-1:0]  rr_q   [SETS];
  logic [19:0]       vpn_q  [SETS][WAYS];
  logic [ASID_W-1:0] asid_q [SETS][WAYS];
  logic [PPN_W-1:0]  ppn_q  [SETS][WAYS];
  logic [7:1]        flg_q  [SETS][WAYS];
  logic              mega_q [SETS][WAYS];

  logic [19:0]       rvpn_q;
  logic [1:0]        acc_q;
  logic [1:0]        priv_q;
  logic              sum_q;
  logic [PPN_W-1:0]  rsp_ppn_q;
  logic              rsp_fault_q;
  logic [IDX_W-1:0]  flush_idx_q;
  logic              flush_all_q;
  logic [ASID_W-1:0] flush_asid_q;

  logic unused_bits;
  assign unused_bits = ^{req_vaddr[11:0], walk_pte[9:8], walk_pte[0]};

  function automatic logic perm_fault(input logic [7:1] f, input logic mega,
                                      input logic [9:0] ppn_lo, input logic [1:0] acc,
                                      input logic [1:0] priv, input logic sum_i);
    logic flt;
    flt = 1'b0;
    case (acc)
      ACC_STORE: flt = !f[2] || !f[7];   // no hardware D update
      ACC_FETCH: flt = !f[3];
      default:   flt = !f[1];
    endcase
    if (f[4] && priv == PRIV_S && (acc == ACC_FETCH || !sum_i)) flt = 1'b1;
    if (!f[4] && priv == PRIV_U) flt = 1'b1;
    if (!f[6]) flt = 1'b1;
    if (mega && ppn_lo != 10'd0) flt = 1'b1;
    return flt;
  endfunction

  // Lookup against the incoming request
  logic [19:0]      req_vpn;
  logic [IDX_W-1:0] req_idx;
  logic             bypass;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [PPN_W-1:0] hit_ppn_raw, hit_ppn;
  logic             hit_fault;

  assign req_vpn = req_vaddr[31:12];
  assign req_idx = req_vpn[IDX_W-1:0];
  assign bypass  = !satp_mode || priv_level == PRIV_M;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && v_q[req_idx][w] &&
          (flg_q[req_idx][w][5] || asid_q[req_idx][w] == satp_asid) &&
          (mega_q[req_idx][w] ? (vpn_q[req_idx][w][19:10] == req_vpn[19:10])
                              : (vpn_q[req_idx][w] == req_vpn))) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_ppn_raw = ppn_q[req_idx][hit_way];
  assign hit_ppn     = mega_q[req_idx][hit_way] ? {hit_ppn_raw[PPN_W-1:10], req_vpn[9:0]}
                                                : hit_ppn_raw;
  assign hit_fault   = perm_fault(flg_q[req_idx][hit_way], mega_q[req_idx][hit_way],
                                  hit_ppn_raw[9:0], req_acc, priv_level, sum);

  // Walk result and fill
  logic [IDX_W-1:0] fill_idx;
  logic [PPN_W-1:0] pte_ppn, walk_ppn;
  logic             walk_fault;
  logic             fill_en;
  logic             have_inv;
  logic [WAY_W-1:0] victim;

  assign fill_idx   = rvpn_q[IDX_W-1:0];
  assign pte_ppn    = walk_pte[10 +: PPN_W];
  assign walk_ppn   = walk_mega ? {pte_ppn[PPN_W-1:10], rvpn_q[9:0]} : pte_ppn;
  assign walk_fault = walk_err || perm_fault(walk_pte[7:1], walk_mega, pte_ppn[9:0],
                                             acc_q, priv_q, sum_q);
  assign fill_en    = (state_q == S_WALK) && walk_done && !walk_err;

  // An empty way is taken before the round-robin victim and leaves the pointer alone
  always_comb begin
    victim   = rr_q[fill_idx];
    have_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!have_inv && !v_q[fill_idx][w]) begin
        have_inv = 1'b1;
        victim   = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    walk_req   = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (flush_req)      state_d = S_FLUSH;
        else if (req_valid) state_d = (bypass || hit) ? S_RESP : S_WALK;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      S_WALK: begin
        walk_req = 1'b1;
        if (walk_done) state_d = S_RESP;
      end
      S_FLUSH: begin
        if (flush_idx_q == IDX_W'(SETS - 1)) begin
          flush_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign walk_vpn  = walk_req ? rvpn_q : 20'd0;
  assign rsp_ppn   = rsp_valid ? rsp_ppn_q : '0;
  assign rsp_fault = rsp_valid & rsp_fault_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rvpn_q       <= '0;
      acc_q        <= '0;
      priv_q       <= '0;
      sum_q        <= 1'b0;
      rsp_ppn_q    <= '0;
      rsp_fault_q  <= 1'b0;
      flush_idx_q  <= '0;
      flush_all_q  <= 1'b0;
      flush_asid_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        v_q[s]  <= '0;
        rr_q[s] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            flush_idx_q  <= '0;
            flush_all_q  <= flush_all;
            flush_asid_q <= flush_asid;
          end else if (req_valid) begin
            rvpn_q <= req_vpn;
            acc_q  <= req_acc;
            priv_q <= priv_level;
            sum_q  <= sum;
            if (bypass) begin
              rsp_ppn_q   <= PPN_W'(req_vpn);
              rsp_fault_q <= 1'b0;
            end else if (hit) begin
              rsp_ppn_q   <= hit_fault ? '0 : hit_ppn;
              rsp_fault_q <= hit_fault;
            end
          end
        end
        S_WALK: begin
          if (walk_done) begin
            rsp_ppn_q   <= walk_fault ? '0 : walk_ppn;
            rsp_fault_q <= walk_fault;
            if (!walk_err) begin
              v_q[fill_idx][victim] <= 1'b1;
              if (!have_inv)
                rr_q[fill_idx] <= (rr_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                      : rr_q[fill_idx] + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            if (flush_all_q ||
                (!flg_q[flush_idx_q][w][5] && asid_q[flush_idx_q][w] == flush_asid_q))
              v_q[flush_idx_q][w] <= 1'b0;
          end
          flush_idx_q <= flush_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_en) begin
      vpn_q[fill_idx][victim]  <= rvpn_q;
      asid_q[fill_idx][victim] <= satp_asid;
      ppn_q[fill_idx][victim]  <= pte_ppn;
      flg_q[fill_idx][victim]  <= walk_pte[7:1];
      mega_q[fill_idx][victim] <= walk_mega;
    end
  end

endmodule

// File: tb/tb_tlb_assoc.sv
module tb_tlb_assoc;

  localparam int SETS = 8;

  localparam logic [7:0] FV = 8'h01, FR = 8'h02, FW = 8'h04, FX = 8'h08;
  localparam logic [7:0] FU = 8'h10, FG = 8'h20, FA = 8'h40, FD = 8'h80;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        satp_mode;
  logic [8:0]  satp_asid;
  logic [1:0]  priv_level;
  logic        sum;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic [1:0]  req_acc;
  logic        rsp_valid;
  logic [21:0] rsp_ppn;
  logic        rsp_fault;
  logic        walk_req;
  logic [19:0] walk_vpn;
  logic        walk_done;
  logic [31:0] walk_pte;
  logic        walk_mega;
  logic        walk_err;
  logic        flush_req;
  logic        flush_all;
  logic [8:0]  flush_asid;
  logic        flush_done;

  int checks = 0;
  int errors = 0;

  tlb_assoc dut (
    .CLK(CLK), .nRST(nRST), .satp_mode(satp_mode), .satp_asid(satp_asid),
    .priv_level(priv_level), .sum(sum), .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .req_acc(req_acc), .rsp_valid(rsp_valid), .rsp_ppn(rsp_ppn),
    .rsp_fault(rsp_fault), .walk_req(walk_req), .walk_vpn(walk_vpn), .walk_done(walk_done),
    .walk_pte(walk_pte), .walk_mega(walk_mega), .walk_err(walk_err), .flush_req(flush_req),
    .flush_all(flush_all), .flush_asid(flush_asid), .flush_done(flush_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mkpte(input logic [21:0] ppn, input logic [7:0] flags);
    return {ppn, 2'b00, flags};
  endfunction

  // One request; services a walk with the given result if the DUT asks for one.
  // lat counts falling edges from the request cycle to rsp_valid (-1 on timeout).
  task automatic txn(input logic [31:0] va, input logic [1:0] acc, input logic [31:0] pte,
                     input logic mega, input logic err, output logic walked,
                     output logic [19:0] wvpn, output logic [21:0] ppn, output logic fault,
                     output int lat);
    walked = 1'b0; wvpn = '0; ppn = '0; fault = 1'b0; lat = -1;
    @(negedge CLK);
    req_valid = 1'b1; req_vaddr = va; req_acc = acc;
    @(negedge CLK);
    req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (rsp_valid) begin
        ppn = rsp_ppn; fault = rsp_fault; lat = i;
        break;
      end
      if (walk_req && !walked) begin
        walked = 1'b1; wvpn = walk_vpn;
        walk_done = 1'b1; walk_pte = pte; walk_mega = mega; walk_err = err;
      end
      @(negedge CLK);
      walk_done = 1'b0; walk_mega = 1'b0; walk_err = 1'b0;
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    satp_mode = 1'b1; satp_asid = 9'd1; priv_level = 2'd1; sum = 1'b0;
    req_valid = 1'b0; req_vaddr = '0; req_acc = '0;
    walk_done = 1'b0; walk_pte = '0; walk_mega = 1'b0; walk_err = 1'b0;
    flush_req = 1'b0; flush_all = 1'b0; flush_asid = '0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (walk_req !== 1'b0) begin errors++; $display("FAIL reset_walk_req: got %b expected 0", walk_req); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b expected 0", flush_done); end
    checks++; if (rsp_ppn !== 22'd0) begin errors++; $display("FAIL reset_rsp_ppn: got %h expected 0", rsp_ppn); end
  endtask

  task automatic test_walk_hit();
    logic w; logic [19:0] vp; logic [21:0] p; logic f; int l;
    satp_asid = 9'd1; priv_level = 2'd1;
    txn(32'h4000_1234, 2'd0, mkpte(22'h12345, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL miss_walk_req: got %b expected 1", w); end
    checks++; if (vp !== 20'h40001) begin errors++; $display("FAIL miss_walk_vpn: got %h expected 40001", vp); end
    checks++; if (p !== 22'h12345) begin errors++; $display("FAIL miss_ppn: got %h expected 12345", p); end
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL miss_fault: got %b expected 0", f); end
    checks++; if (l !== 2) begin errors++; $display("FAIL miss_latency: got %0d expected 2", l); end
    txn(32'h4000_1234, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL hit_no_walk: got %b expected 0", w); end
    checks++; if (l !== 1) begin errors++; $display("FAIL hit_latency: got %0d expected 1", l); end
    checks++; if (p !== 22'h12345) begin errors++; $display("FAIL hit_ppn: got %h expected 12345", p); end
  endtask

  task automatic test_perm();
    logic w; logic [19:0] vp; logic [21:0] p; logic f; int l;
    txn(32'h5000_2000, 2'd1, mkpte(22'h00ABC, FV|FR|FW|FA), 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (f !== 1'b1 || p !== 22'd0) begin errors++; $display("FAIL store_d0_fault: got fault %b ppn %h expected 1 0", f, p); end
    txn(32'h5000_2000, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b0 || f !== 1'b0 || p !== 22'h00ABC) begin errors++; $display("FAIL load_same_page: got walk %b fault %b ppn %h expected 0 0 abc", w, f, p); end
    txn(32'h5000_2000, 2'd2, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL fetch_x0_fault: got %b expected 1", f); end
    priv_level = 2'd0;
    txn(32'h4000_1234, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (f !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL umode_supage: got fault %b walk %b expected 1 0", f, w); end
    priv_level = 2'd1; sum = 1'b0;
    txn(32'h5000_3000, 2'd0, mkpte(22'h00777, FV|FR|FU|FA), 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL smode_upage_sum0: got %b expected 1", f); end
    sum = 1'b1;
    txn(32'h5000_3000, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (f !== 1'b0 || p !== 22'h00777) begin errors++; $display("FAIL smode_upage_sum1: got fault %b ppn %h expected 0 777", f, p); end
    sum = 1'b0;
  endtask

  task automatic test_mega();
    logic w; logic [19:0] vp; logic [21:0] p; logic f; int l;
    txn(32'h8040_3000, 2'd0, mkpte(22'h00400, FV|FR|FA), 1'b1, 1'b0, w, vp, p, f, l);
    checks++; if (p !== 22'h00403 || f !== 1'b0) begin errors++; $display("FAIL mega_fill_ppn: got ppn %h fault %b expected 403 0", p, f); end
    txn(32'h8040_B000, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b0 || p !== 22'h0040B) begin errors++; $display("FAIL mega_hit: got walk %b ppn %h expected 0 40b", w, p); end
    txn(32'hC000_0000, 2'd0, mkpte(22'h00401, FV|FR|FA), 1'b1, 1'b0, w, vp, p, f, l);
    checks++; if (f !== 1'b1 || p !== 22'd0) begin errors++; $display("FAIL mega_misaligned: got fault %b ppn %h expected 1 0", f, p); end
  endtask

  task automatic test_walk_err();
    logic w; logic [19:0] vp; logic [21:0] p; logic f; int l;
    txn(32'h6000_0000, 2'd0, mkpte(22'h00111, FV|FR|FA), 1'b0, 1'b1, w, vp, p, f, l);
    checks++; if (f !== 1'b1 || p !== 22'd0 || l !== 2) begin errors++; $display("FAIL walk_err_rsp: got fault %b ppn %h lat %0d expected 1 0 2", f, p, l); end
    txn(32'h6000_0000, 2'd0, mkpte(22'h00111, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b1 || p !== 22'h00111) begin errors++; $display("FAIL walk_err_nofill: got walk %b ppn %h expected 1 111", w, p); end
  endtask

  task automatic test_rr_evict();
    logic w; logic [19:0] vp; logic [21:0] p; logic f; int l;
    txn(32'h1000_5000, 2'd0, mkpte(22'h0AAAA, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    txn(32'h1000_D000, 2'd0, mkpte(22'h0BBBB, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    txn(32'h1001_5000, 2'd0, mkpte(22'h0CCCC, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b1 || p !== 22'h0CCCC) begin errors++; $display("FAIL rr_third_fill: got walk %b ppn %h expected 1 cccc", w, p); end
    txn(32'h1000_D000, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b0 || p !== 22'h0BBBB) begin errors++; $display("FAIL rr_second_kept: got walk %b ppn %h expected 0 bbbb", w, p); end
    txn(32'h1000_5000, 2'd0, mkpte(22'h0AAAA, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL rr_first_evicted: got walk %b expected 1", w); end
    txn(32'h1001_5000, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b0 || p !== 22'h0CCCC) begin errors++; $display("FAIL rr_third_kept: got walk %b ppn %h expected 0 cccc", w, p); end
  endtask

  task automatic test_flush_asid();
    logic w; logic [19:0] vp; logic [21:0] p; logic f; int l; int n; logic rdy1;
    satp_asid = 9'd3;
    txn(32'h2000_6000, 2'd0, mkpte(22'h00333, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    txn(32'h3000_6000, 2'd0, mkpte(22'h00666, FV|FR|FA|FG), 1'b0, 1'b0, w, vp, p, f, l);
    satp_asid = 9'd5;
    txn(32'h2000_7000, 2'd0, mkpte(22'h00555, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    @(negedge CLK);
    flush_req = 1'b1; flush_all = 1'b0; flush_asid = 9'd3;
    @(negedge CLK);
    flush_req = 1'b0;
    n = -1; rdy1 = req_ready;
    for (int i = 1; i <= 40; i++) begin
      if (flush_done) begin n = i; break; end
      @(negedge CLK);
    end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL flush_busy_ready: got %b expected 0", rdy1); end
    checks++; if (n !== SETS) begin errors++; $display("FAIL flush_cycles: got %0d expected %0d", n, SETS); end
    @(negedge CLK);
    checks++; if (flush_done !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL flush_after: got done %b ready %b expected 0 1", flush_done, req_ready); end
    txn(32'h2000_7000, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b0 || p !== 22'h00555) begin errors++; $display("FAIL flush_asid5_kept: got walk %b ppn %h expected 0 555", w, p); end
    txn(32'h3000_6000, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b0 || p !== 22'h00666) begin errors++; $display("FAIL flush_global_kept: got walk %b ppn %h expected 0 666", w, p); end
    satp_asid = 9'd3;
    txn(32'h2000_6000, 2'd0, mkpte(22'h00333, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL flush_asid3_gone: got walk %b expected 1", w); end
  endtask

  task automatic test_flush_priority();
    logic w; logic [19:0] vp; logic [21:0] p; logic f; int l; int n; logic busy;
    @(negedge CLK);
    flush_req = 1'b1; flush_all = 1'b1; flush_asid = 9'd0;
    req_valid = 1'b1; req_vaddr = 32'h3000_6000; req_acc = 2'd0;
    @(negedge CLK);
    flush_req = 1'b0; req_valid = 1'b0;
    n = -1; busy = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (rsp_valid || walk_req) busy = 1'b1;
      if (flush_done) begin n = i; break; end
      @(negedge CLK);
    end
    checks++; if (busy !== 1'b0 || n !== SETS) begin errors++; $display("FAIL flush_priority: got req_seen %b cycles %0d expected 0 %0d", busy, n, SETS); end
    txn(32'h3000_6000, 2'd0, mkpte(22'h00666, FV|FR|FA|FG), 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL flush_all_global: got walk %b expected 1", w); end
  endtask

  task automatic test_bare();
    logic w; logic [19:0] vp; logic [21:0] p; logic f; int l;
    satp_mode = 1'b0;
    txn(32'hFFFF_F000, 2'd1, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (p !== 22'h0FFFFF || f !== 1'b0 || w !== 1'b0 || l !== 1) begin errors++; $display("FAIL bare_pass: got ppn %h fault %b walk %b lat %0d expected 0fffff 0 0 1", p, f, w, l); end
    satp_mode = 1'b1; priv_level = 2'd3;
    txn(32'h1234_5678, 2'd2, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (p !== 22'h012345 || f !== 1'b0 || w !== 1'b0) begin errors++; $display("FAIL mmode_pass: got ppn %h fault %b walk %b expected 012345 0 0", p, f, w); end
    priv_level = 2'd1;
  endtask

  task automatic test_reset_mid_walk();
    logic w; logic [19:0] vp; logic [21:0] p; logic f; int l;
    satp_asid = 9'd1;
    txn(32'h4000_1234, 2'd0, mkpte(22'h12345, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    txn(32'h4000_1234, 2'd0, 32'h0, 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL prereset_hit: got walk %b expected 0", w); end
    @(negedge CLK);
    req_valid = 1'b1; req_vaddr = 32'h7000_0000; req_acc = 2'd0;
    @(negedge CLK);
    req_valid = 1'b0;
    checks++; if (walk_req !== 1'b1 || walk_vpn !== 20'h70000) begin errors++; $display("FAIL midwalk_req: got %b vpn %h expected 1 70000", walk_req, walk_vpn); end
    #2 nRST = 1'b0;
    #1;
    checks++; if (walk_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midwalk_reset: got walk_req %b ready %b expected 0 1", walk_req, req_ready); end
    @(negedge CLK);
    nRST = 1'b1;
    txn(32'h4000_1234, 2'd0, mkpte(22'h12345, FV|FR|FA), 1'b0, 1'b0, w, vp, p, f, l);
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL postreset_empty: got walk %b expected 1", w); end
  endtask

  initial begin
    test_reset();
    test_walk_hit();
    test_perm();
    test_mega();
    test_walk_err();
    test_rr_evict();
    test_flush_asid();
    test_flush_priority();
    test_bare();
    test_reset_mid_walk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
